tm1637_responder: RTL and testbench

- Device-side endpoint of the TM1637 two-wire CLK/DIO protocol; the counterpart of the LED_TM1637 initiator and its SPI master in DIO mode.
- Oversamples the bus on the 50 MHz system clock.
- Decodes start/stop, LSB-first bytes and the TM1637 command set, and drives ACK and key-scan bits through an open-drain enable.
- Delivers display-RAM writes and display-control state to local logic. Used as an on-board loopback target and as the bench model for the initiator.

---
 rtl/tm1637_pkg.sv | 11 +
 rtl/tm1637_bus_sync.sv | 43 ++++
 rtl/tm1637_responder.sv | 217 +++++++++++++++++++++
 tb/tb_tm1637_responder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_pkg.sv
// tm1637_pkg: shared command classes, command bit positions, byte-FSM states and address width
package tm1637_pkg;
    localparam int TM_ADDR_W = 3;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;
    localparam int DC_FIXED_BIT = 2;
    localparam int DC_READ_BIT = 1;
    localparam int CC_ON_BIT = 3;
    typedef enum logic [2:0] {ST_IDLE, ST_RX_BIT, ST_ACK, ST_TX_BIT, ST_TX_ACK} byte_state_t;
endpackage

// File: rtl/tm1637_bus_sync.sv
// tm1637_bus_sync: synchronises tm_clk/tm_dio_in and detects CLK edges plus start/stop conditions
//   clk_50M, rst_n         : system clock, async active-low reset
//   tm_clk, tm_dio_in      : asynchronous bus lines
//   clk_rise, clk_fall     : one-cycle CLK edge strobes
//   start, stop            : DIO fall / rise while CLK is steadily high
//   dio_sync               : synchronised DIO level
module tm1637_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic tm_clk,
    input  logic tm_dio_in,
    output logic clk_rise,
    output logic clk_fall,
    output logic start,
    output logic stop,
    output logic dio_sync
);
    logic [SYNC_STAGES-1:0] clk_sr, dio_sr;
    logic clk_q, dio_q, clk_s;
    // Idle bus is high, so resetting to 1 avoids phantom edges on release
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr <= '1;
            dio_sr <= '1;
            clk_q <= 1'b1;
            dio_q <= 1'b1;
        end else begin
            clk_sr <= {clk_sr[SYNC_STAGES-2:0], tm_clk};
            dio_sr <= {dio_sr[SYNC_STAGES-2:0], tm_dio_in};
            clk_q <= clk_sr[SYNC_STAGES-1];
            dio_q <= dio_sr[SYNC_STAGES-1];
        end
    end
    assign clk_s = clk_sr[SYNC_STAGES-1];
    assign dio_sync = dio_sr[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_q;
    assign clk_fall = ~clk_s & clk_q;
    // Requiring CLK high in both samples makes a simultaneous CLK/DIO change a CLK edge only
    assign start = clk_s & clk_q & dio_q & ~dio_sync;
    assign stop = clk_s & clk_q & ~dio_q & dio_sync;
endmodule

// File: rtl/tm1637_responder.sv
// tm1637_responder: TM1637 device-side endpoint decoding commands into display writes and control state
//   clk_50M, rst_n                          : system clock, async active-low reset
//   tm_clk, tm_dio_in / tm_dio_oe           : bus CLK, sensed DIO, open-drain pull-low enable
//   key_data                                : byte returned on a read command
//   seg_wr_en/seg_wr_addr/seg_wr_data       : display-RAM write strobe, address, data
//   disp_on, brightness                     : display control state
//   frame_done, proto_err                   : one-cycle frame status pulses
module tm1637_responder
    import tm1637_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 tm_clk,
    input  logic                 tm_dio_in,
    output logic                 tm_dio_oe,
    input  logic [7:0]           key_data,
    output logic                 seg_wr_en,
    output logic [TM_ADDR_W-1:0] seg_wr_addr,
    output logic [7:0]           seg_wr_data,
    output logic                 disp_on,
    output logic [2:0]           brightness,
    output logic                 frame_done,
    output logic                 proto_err
);
    logic clk_rise, clk_fall, start, stop, dio_sync;
    byte_state_t state, state_n;
    logic [7:0] sr, sr_n, tx_byte, tx_byte_n, rx_byte, seg_wr_data_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [TM_ADDR_W-1:0] addr_ptr, addr_ptr_n, seg_wr_addr_n;
    logic [2:0] brightness_n;
    logic bit_hi, bit_hi_n, fixed_addr, fixed_addr_n, read_mode, read_mode_n;
    logic want_cmd, want_cmd_n, have_addr, have_addr_n, ignore, ignore_n, data_cmd, data_cmd_n;
    logic oe_n, disp_on_n, seg_wr_en_n, frame_done_n, proto_err_n;

    tm1637_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .tm_clk   (tm_clk),
        .tm_dio_in(tm_dio_in),
        .clk_rise (clk_rise),
        .clk_fall (clk_fall),
        .start    (start),
        .stop     (stop),
        .dio_sync (dio_sync)
    );

    assign rx_byte = {dio_sync, sr[7:1]};

    always_comb begin
        state_n = state;
        sr_n = sr;
        bit_cnt_n = bit_cnt;
        bit_hi_n = bit_hi;
        tx_byte_n = tx_byte;
        addr_ptr_n = addr_ptr;
        fixed_addr_n = fixed_addr;
        read_mode_n = read_mode;
        want_cmd_n = want_cmd;
        have_addr_n = have_addr;
        ignore_n = ignore;
        data_cmd_n = data_cmd;
        oe_n = tm_dio_oe;
        disp_on_n = disp_on;
        brightness_n = brightness;
        seg_wr_addr_n = seg_wr_addr;
        seg_wr_data_n = seg_wr_data;
        seg_wr_en_n = 1'b0;
        frame_done_n = 1'b0;
        proto_err_n = 1'b0;
        if (start) begin
            state_n = ST_RX_BIT;
            oe_n = 1'b0;
            bit_cnt_n = '0;
            bit_hi_n = 1'b0;
            want_cmd_n = 1'b1;
            have_addr_n = 1'b0;
            ignore_n = 1'b0;
            data_cmd_n = 1'b0;
        end else if (stop) begin
            state_n = ST_IDLE;
            oe_n = 1'b0;
            // The stop condition's own CLK rise was counted as a bit; bit_hi removes it
            if (state != ST_IDLE && !ignore) begin
                if (state == ST_RX_BIT && bit_cnt != {3'b000, bit_hi})
                    proto_err_n = 1'b1;
                else
                    frame_done_n = 1'b1;
            end
        end else begin
            case (state)
                ST_RX_BIT: begin
                    if (clk_rise) begin
                        sr_n = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        bit_hi_n = 1'b1;
                        if (bit_cnt == 4'd7 && !ignore) begin
                            if (want_cmd) begin
                                want_cmd_n = 1'b0;
                                case (rx_byte[7:6])
                                    CMD_DATA: begin
                                        fixed_addr_n = rx_byte[DC_FIXED_BIT];
                                        read_mode_n = rx_byte[DC_READ_BIT];
                                        data_cmd_n = 1'b1;
                                    end
                                    CMD_ADDR: begin
                                        addr_ptr_n = rx_byte[TM_ADDR_W-1:0];
                                        have_addr_n = 1'b1;
                                    end
                                    CMD_CTRL: begin
                                        disp_on_n = rx_byte[CC_ON_BIT];
                                        brightness_n = rx_byte[2:0];
                                    end
                                    default: begin
                                        proto_err_n = 1'b1;
                                        ignore_n = 1'b1;
                                    end
                                endcase
                            end else if (have_addr) begin
                                if (int'(addr_ptr) < NUM_DIGITS) begin
                                    seg_wr_en_n = 1'b1;
                                    seg_wr_addr_n = addr_ptr;
                                    seg_wr_data_n = rx_byte;
                                end
                                addr_ptr_n = fixed_addr ? addr_ptr : addr_ptr + 3'd1;
                            end
                        end
                    end else if (clk_fall) begin
                        bit_hi_n = 1'b0;
                        if (bit_cnt == 4'd8) begin
                            state_n = ST_ACK;
                            oe_n = 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (clk_fall) begin
                        bit_cnt_n = '0;
                        bit_hi_n = 1'b0;
                        data_cmd_n = 1'b0;
                        // Releasing ACK and presenting key bit 0 share the same edge
                        state_n = (data_cmd && read_mode) ? ST_TX_BIT : ST_RX_BIT;
                        tx_byte_n = key_data;
                        oe_n = (data_cmd && read_mode) ? ~key_data[0] : 1'b0;
                    end
                end
                ST_TX_BIT: begin
                    if (clk_fall) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        state_n = (bit_cnt == 4'd7) ? ST_TX_ACK : ST_TX_BIT;
                        oe_n = (bit_cnt == 4'd7) ? 1'b0 : ~tx_byte[bit_cnt[2:0] + 3'd1];
                    end
                end
                ST_TX_ACK: begin
                    if (clk_fall) begin
                        state_n = ST_RX_BIT;
                        bit_cnt_n = '0;
                        bit_hi_n = 1'b0;
                    end
                end
                ST_IDLE: state_n = ST_IDLE;
                default: begin
                    state_n = ST_IDLE;
                    oe_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sr <= '0;
            bit_cnt <= '0;
            bit_hi <= 1'b0;
            tx_byte <= '0;
            addr_ptr <= '0;
            fixed_addr <= 1'b0;
            read_mode <= 1'b0;
            want_cmd <= 1'b0;
            have_addr <= 1'b0;
            ignore <= 1'b0;
            data_cmd <= 1'b0;
            tm_dio_oe <= 1'b0;
            disp_on <= 1'b0;
            brightness <= '0;
            seg_wr_en <= 1'b0;
            seg_wr_addr <= '0;
            seg_wr_data <= '0;
            frame_done <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            bit_cnt <= bit_cnt_n;
            bit_hi <= bit_hi_n;
            tx_byte <= tx_byte_n;
            addr_ptr <= addr_ptr_n;
            fixed_addr <= fixed_addr_n;
            read_mode <= read_mode_n;
            want_cmd <= want_cmd_n;
            have_addr <= have_addr_n;
            ignore <= ignore_n;
            data_cmd <= data_cmd_n;
            tm_dio_oe <= oe_n;
            disp_on <= disp_on_n;
            brightness <= brightness_n;
            seg_wr_en <= seg_wr_en_n;
            seg_wr_addr <= seg_wr_addr_n;
            seg_wr_data <= seg_wr_data_n;
            frame_done <= frame_done_n;
            proto_err <= proto_err_n;
        end
    end
endmodule

// File: tb/tb_tm1637_responder.sv
// tb_tm1637_responder: bus-level initiator with a frame-level reference model and event scoreboard
module tb_tm1637_responder;
    localparam int ND = 6;
    localparam int SS = 2;
    localparam int H = 6;

    logic clk_50M = 1'b0;
    logic rst_n = 1'b0;
    logic m_clk = 1'b1;
    logic m_dio = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic tm_dio_in, tm_dio_oe, seg_wr_en, disp_on, frame_done, proto_err;
    logic [2:0] seg_wr_addr, brightness;
    logic [7:0] seg_wr_data;

    assign tm_dio_in = m_dio & ~tm_dio_oe;

    tm1637_responder #(.NUM_DIGITS(ND), .SYNC_STAGES(SS)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .tm_clk     (m_clk),
        .tm_dio_in  (tm_dio_in),
        .tm_dio_oe  (tm_dio_oe),
        .key_data   (key_data),
        .seg_wr_en  (seg_wr_en),
        .seg_wr_addr(seg_wr_addr),
        .seg_wr_data(seg_wr_data),
        .disp_on    (disp_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .proto_err  (proto_err)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {int kind; int addr; int data; int t;} ev_t;
    ev_t expq[$];
    ev_t e;
    int kind;
    int cyc = 0;
    int last_edge = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_wr = 0, n_fd = 0, n_pe = 0;
    int last_addr = 0, last_data = 0;
    logic [7:0] last_rx = 8'h00;
    bit m_in_frame = 0, m_first = 0, m_have = 0, m_ign = 0, m_fixed = 0, m_rdcmd = 0;
    bit m_disp = 0;
    int m_ptr = 0, m_bri = 0;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int a, input int d);
        ev_t x;
        x.kind = k;
        x.addr = a;
        x.data = d;
        x.t = cyc;
        expq.push_back(x);
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk_50M);
        #2;
    endtask

    task automatic set_clk(input logic v);
        m_clk = v;
        last_edge = cyc;
    endtask

    // Frame-level meaning of one complete byte, applied when its 8th CLK rise hits the pin
    task automatic model_byte(input logic [7:0] b);
        if (m_ign) return;
        if (m_first) begin
            m_first = 0;
            case (b[7:6])
                2'b01: begin m_fixed = b[2]; m_rdcmd = b[1]; end
                2'b11: begin m_ptr = int'(b[2:0]); m_have = 1; end
                2'b10: begin m_disp = b[3]; m_bri = int'(b[2:0]); end
                default: begin push(2, 0, 0); m_ign = 1; end
            endcase
        end else if (m_have) begin
            if (m_ptr < ND) push(0, m_ptr, int'(b));
            if (!m_fixed) m_ptr = (m_ptr + 1) % 8;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 0; i < n; i++) begin
            m_dio = b[i];
            wt(H);
            set_clk(1'b1);
            wt(H);
            s = tm_dio_in;
            check("dio data bit", 32'(s), 32'(b[i]));
            set_clk(1'b0);
            wt(H);
        end
    endtask

    task automatic recv_byte();
        logic s;
        logic [7:0] exp_k;
        exp_k = key_data;
        for (int i = 0; i < 8; i++) begin
            m_dio = 1'b1;
            wt(H);
            set_clk(1'b1);
            wt(H);
            s = tm_dio_in;
            last_rx[i] = s;
            check("key bit on dio", 32'(s), 32'(exp_k[i]));
            set_clk(1'b0);
            if (i == 0) key_data = 8'($urandom);
            wt(H);
        end
        m_dio = 1'b1;
        wt(H);
        set_clk(1'b1);
        wt(H);
        check("dio released on read ack clock", 32'(tm_dio_in), 32'd1);
        set_clk(1'b0);
        wt(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic s;
        for (int i = 0; i < 8; i++) begin
            m_dio = b[i];
            wt(H);
            set_clk(1'b1);
            if (i == 7) model_byte(b);
            wt(H);
            s = tm_dio_in;
            check("dio data bit", 32'(s), 32'(b[i]));
            set_clk(1'b0);
            wt(H);
        end
        m_dio = 1'b1;
        wt(H);
        set_clk(1'b1);
        wt(H);
        check("ack low on 9th clock", 32'(tm_dio_in), 32'd0);
        set_clk(1'b0);
        wt(H);
        if (m_rdcmd) begin
            m_rdcmd = 0;
            recv_byte();
        end
    endtask

    task automatic do_start();
        m_dio = 1'b1;
        set_clk(1'b1);
        wt(H);
        m_dio = 1'b0;
        wt(H);
        set_clk(1'b0);
        wt(H);
        m_in_frame = 1;
        m_first = 1;
        m_have = 0;
        m_ign = 0;
        m_rdcmd = 0;
    endtask

    task automatic do_stop(input int partial_bits);
        m_dio = 1'b0;
        wt(H);
        set_clk(1'b1);
        wt(H);
        m_dio = 1'b1;
        if (m_in_frame && !m_ign) push(partial_bits != 0 ? 2 : 1, 0, 0);
        m_in_frame = 0;
        wt(H);
    endtask

    always @(negedge clk_50M) begin
        if (rst_n) begin
            if (seg_wr_en || frame_done || proto_err) begin
                kind = seg_wr_en ? 0 : (frame_done ? 1 : 2);
                check("single pulse per cycle", 32'(seg_wr_en) + 32'(frame_done) + 32'(proto_err), 32'd1);
                if (expq.size() == 0) begin
                    check("unexpected pulse kind", 32'(kind), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("event kind", 32'(kind), 32'(e.kind));
                    if (kind == 0) begin
                        check("wr addr", 32'(seg_wr_addr), 32'(e.addr));
                        check("wr data", 32'(seg_wr_data), 32'(e.data));
                        check("wr latency within bound", 32'(cyc - e.t <= SS + 2), 32'd1);
                        n_wr++;
                        last_addr = int'(seg_wr_addr);
                        last_data = int'(seg_wr_data);
                    end
                    if (kind == 1) n_fd++;
                    if (kind == 2) n_pe++;
                end
            end
            if (cyc - last_edge > SS + 3) begin
                check("disp_on", 32'(disp_on), 32'(m_disp));
                check("brightness", 32'(brightness), 32'(m_bri));
            end
        end
    end

    task automatic check_reset_outputs();
        check("reset tm_dio_oe", 32'(tm_dio_oe), 32'd0);
        check("reset seg_wr_en", 32'(seg_wr_en), 32'd0);
        check("reset seg_wr_addr", 32'(seg_wr_addr), 32'd0);
        check("reset seg_wr_data", 32'(seg_wr_data), 32'd0);
        check("reset disp_on", 32'(disp_on), 32'd0);
        check("reset brightness", 32'(brightness), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset proto_err", 32'(proto_err), 32'd0);
    endtask

    initial begin
        int w0, f0, p0, nb;
        logic [7:0] b;
        wt(4);
        check_reset_outputs();
        rst_n = 1'b1;
        wt(4);

        do_start(); send_byte(8'h40); do_stop(0);
        w0 = n_wr; f0 = n_fd;
        do_start(); send_byte(8'hC0); send_byte(8'h3F); send_byte(8'h06); send_byte(8'h5B); do_stop(0);
        wt(6);
        check("lit writes in incrementing frame", 32'(n_wr - w0), 32'd3);
        check("lit last write addr", 32'(last_addr), 32'd2);
        check("lit last write data", 32'(last_data), 32'h5B);
        check("lit frame_done once", 32'(n_fd - f0), 32'd1);

        do_start(); send_byte(8'h44); do_stop(0);
        w0 = n_wr;
        do_start(); send_byte(8'hC3); send_byte(8'h7F); send_byte(8'h6D); do_stop(0);
        wt(6);
        check("lit fixed-mode writes", 32'(n_wr - w0), 32'd2);
        check("lit fixed-mode addr", 32'(last_addr), 32'd3);
        check("lit fixed-mode data", 32'(last_data), 32'h6D);

        w0 = n_wr;
        do_start(); send_byte(8'h8F); do_stop(0);
        wt(6);
        check("lit disp_on after 0x8F", 32'(disp_on), 32'd1);
        check("lit brightness after 0x8F", 32'(brightness), 32'd7);
        do_start(); send_byte(8'h80); do_stop(0);
        wt(6);
        check("lit disp_on after 0x80", 32'(disp_on), 32'd0);
        check("lit brightness after 0x80", 32'(brightness), 32'd0);
        check("lit no writes from control", 32'(n_wr - w0), 32'd0);

        key_data = 8'hA5;
        do_start(); send_byte(8'h42); do_stop(0);
        check("lit key byte read back", 32'(last_rx), 32'hA5);

        do_start(); send_byte(8'h40); do_stop(0);
        w0 = n_wr;
        do_start(); send_byte(8'hC5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); do_stop(0);
        wt(6);
        check("lit writes with dropped addresses", 32'(n_wr - w0), 32'd2);
        check("lit wrapped write addr", 32'(last_addr), 32'd0);
        check("lit wrapped write data", 32'(last_data), 32'h44);

        p0 = n_pe; f0 = n_fd;
        do_start(); send_byte(8'h1A); send_byte(8'h55); do_stop(0);
        wt(6);
        check("lit invalid command proto_err", 32'(n_pe - p0), 32'd1);
        check("lit invalid command no frame_done", 32'(n_fd - f0), 32'd0);

        w0 = n_wr; p0 = n_pe; f0 = n_fd;
        do_start(); send_bits(8'h15, 5); do_stop(5);
        wt(6);
        check("lit partial byte proto_err", 32'(n_pe - p0), 32'd1);
        check("lit partial byte no frame_done", 32'(n_fd - f0), 32'd0);
        check("lit partial byte no write", 32'(n_wr - w0), 32'd0);

        do_start(); send_bits(8'h40, 8);
        check("ack asserted before reset", 32'(tm_dio_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        m_in_frame = 0; m_fixed = 0; m_ptr = 0; m_disp = 0; m_bri = 0;
        check("no pending events at reset", 32'(expq.size()), 32'd0);
        m_dio = 1'b1;
        set_clk(1'b1);
        wt(4);
        rst_n = 1'b1;
        wt(4);

        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 5))
                0: begin
                    b = 8'h40 | (($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00);
                    do_start(); send_byte(b); do_stop(0);
                    do_start(); send_byte(8'hC0 | 8'($urandom_range(0, 7)));
                    nb = $urandom_range(1, 5);
                    for (int i = 0; i < nb; i++) send_byte(8'($urandom));
                    do_stop(0);
                end
                1: begin do_start(); send_byte(8'h80 | 8'($urandom_range(0, 15))); do_stop(0); end
                2: begin
                    key_data = 8'($urandom);
                    b = 8'h42 | (($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00);
                    do_start(); send_byte(b); do_stop(0);
                end
                3: begin
                    nb = $urandom_range(1, 6);
                    do_start();
                    if ($urandom_range(0, 1) != 0) send_byte(8'hC0 | 8'($urandom_range(0, 7)));
                    send_bits(8'($urandom), nb);
                    do_stop(nb);
                end
                4: begin do_start(); send_byte(8'($urandom_range(0, 63))); send_byte(8'($urandom)); do_stop(0); end
                default: begin
                    b = 8'h40 | (($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00);
                    do_start(); send_byte(b); send_byte(8'($urandom)); do_stop(0);
                end
            endcase
        end
        wt(10);
        check("all expected events seen", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
